// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared UART constants and transmit state encoding
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam int   STOP_BITS  = 1;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - Bit-period counter: tick when count reaches the latched divisor
module uart_baud_tick #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] div_q;

   assign tick = en && (cnt_q == div_q);

   // Divisor is captured once per frame so later changes on div cannot stretch a bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         div_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
         div_q <= div;
      end else if (en) begin
         if (tick) cnt_q <= '0;
         else      cnt_q <= cnt_q + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_tx_ser.sv
// rtl/uart_tx_ser.sv - UART transmit serializer draining the TX FIFO (option: UART_TX_PARITY_EN)
module uart_tx_ser #(
   parameter int DIV_WIDTH = 16,
   parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 parity_odd,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_rddata,
   output logic                 fifo_rd,
   output logic                 txd,
   output logic                 busy,
   output logic                 done
);
   import uart_pkg::*;

   localparam int              BIT_W    = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 txd_q, txd_d;
   logic                 fifo_rd_q, fifo_rd_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 baud_load;
   logic                 baud_en;
   logic                 tick;

`ifdef UART_TX_PARITY_EN
   logic par_q, par_d;

   // Parity of the captured byte, computed once at load time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
`else
   logic unused_parity_odd;
   assign unused_parity_odd = parity_odd;
`endif

   assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

   uart_baud_tick #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .load (baud_load),
      .en   (baud_en),
      .div  (baud_div),
      .tick (tick)
   );

   // State and registered outputs; reset abandons any frame and returns the line to idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         txd_q     <= IDLE_LEVEL;
         fifo_rd_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         txd_q     <= txd_d;
         fifo_rd_q <= fifo_rd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and next-output decode; strobes default low and pulse for one cycle
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      txd_d     = txd_q;
      fifo_rd_d = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      baud_load = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            txd_d = IDLE_LEVEL;
            if (tx_en && !fifo_empty) begin
               fifo_rd_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shreg_d   = fifo_rddata;
            bit_cnt_d = '0;
            baud_load = 1'b1;
            txd_d     = 1'b0;
            state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
            par_d     = (^fifo_rddata) ^ parity_odd;
`endif
         end
         ST_START: begin
            if (tick) begin
               txd_d   = shreg_q[0];
               shreg_d = shreg_q >> 1;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  txd_d   = par_q;
                  state_d = ST_PARITY;
`else
                  txd_d   = IDLE_LEVEL;
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  txd_d     = shreg_q[0];
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               txd_d   = IDLE_LEVEL;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            txd_d   = IDLE_LEVEL;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign txd     = txd_q;
   assign fifo_rd = fifo_rd_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
